// File: rtl/aes_pkg.sv
// Shared types and byte-order helpers for the iterative AES-128 sequencer.
// The state matrix is indexed [row][col]; input bytes fill it column by column.
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef logic [3:0][3:0][7:0] state_t;

  typedef enum logic [1:0] {IDLE, KEY, DONE} fsm_e;

  function automatic state_t to_state(input logic [127:0] b);
    state_t s;
    for (int k = 0; k < 16; k++) s[k%4][k/4] = b[127-8*k -: 8];
    return s;
  endfunction

  function automatic logic [127:0] from_state(input state_t s);
    logic [127:0] b;
    for (int k = 0; k < 16; k++) b[127-8*k -: 8] = s[k%4][k/4];
    return b;
  endfunction

endpackage

// File: rtl/aes_rk_xor.sv
// Byte-wise AddRoundKey; a single instance serves every key addition.
module aes_rk_xor
  import aes_pkg::*;
(
  input  state_t       st,
  input  logic [127:0] rk_key,
  output state_t       res
);

  state_t rk_s;

  assign rk_s = to_state(rk_key);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign res[r][c] = st[r][c] ^ rk_s[r][c];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register, walks the
// external round datapath and pulls one round key per key addition.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         key_load,
  output logic [127:0] cipher_key,
  output logic         rk_req,
  output logic [3:0]   rk_round,
  input  logic         rk_valid,
  input  logic [127:0] rk_key,
  output logic [127:0] rnd_state,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block
);

  localparam logic [3:0] NR_L = 4'(NR);

  fsm_e       fsm;
  state_t     st, sel, nxt;
  logic [3:0] round;

  // Round 0 is the bare whitening key; later rounds go through the datapath.
  assign sel = (round == 4'd0) ? st : to_state(rnd_result);

  aes_rk_xor u_rk_xor (
    .st     (sel),
    .rk_key (rk_key),
    .res    (nxt)
  );

  assign rk_round  = round;
  assign rnd_state = from_state(st);
  assign out_block = from_state(st);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      st         <= '0;
      cipher_key <= '0;
      round      <= '0;
      in_ready   <= 1'b1;
      key_load   <= 1'b0;
      rk_req     <= 1'b0;
      rnd_last   <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      key_load <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (in_valid) begin
            st         <= to_state(in_block);
            cipher_key <= in_key;
            round      <= '0;
            key_load   <= 1'b1;
            in_ready   <= 1'b0;
            rk_req     <= 1'b1;
            rnd_last   <= (NR_L == 4'd0);
            fsm        <= KEY;
          end
        end
        KEY: begin
          if (rk_valid) begin
            st <= nxt;
            if (round == NR_L) begin
              rk_req    <= 1'b0;
              rnd_last  <= 1'b0;
              out_valid <= 1'b1;
              fsm       <= DONE;
            end else begin
              round    <= round + 4'd1;
              rnd_last <= (round + 4'd1 == NR_L);
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: begin
          fsm      <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with an independent AES-128 round and
// key-schedule model standing in for the external datapath and key schedule.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, key_load, rk_req, rk_valid, rnd_last;
  logic         out_valid, out_ready;
  logic [127:0] in_block, in_key, cipher_key, rk_key, rnd_state, rnd_result, out_block;
  logic [3:0]   rk_round;
  logic         stall = 1'b0, spur = 1'b0;
  int           n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_key(in_key), .key_load(key_load), .cipher_key(cipher_key),
    .rk_req(rk_req), .rk_round(rk_round), .rk_valid(rk_valid), .rk_key(rk_key),
    .rnd_state(rnd_state), .rnd_last(rnd_last), .rnd_result(rnd_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block)
  );

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, base;
    int e;
    r = 8'h01; base = x; e = 254;
    while (e > 0) begin
      if ((e % 2) == 1) r = gmul(r, base);
      base = gmul(base, base);
      e = e / 2;
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] tb_round(input logic [127:0] s, input logic last);
    logic [7:0] a [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) a[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[4*c+r] = a[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      if (last) o[127-32*c -: 32] = {t[4*c], t[4*c+1], t[4*c+2], t[4*c+3]};
      else o[127-32*c -: 32] = {
        gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3],
        t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3],
        t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03),
        gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] tb_rkey(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    int idx;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    idx = (n > 10) ? 10 : n;
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  assign rk_valid   = (rk_req & ~stall) | spur;
  assign rk_key     = tb_rkey(cipher_key, int'(rk_round));
  assign rnd_result = tb_round(rnd_state, rnd_last);

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"}, 128'(in_ready), 128'd1);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'd0);
    chk({tag, ".rk_req"}, 128'(rk_req), 128'd0);
    chk({tag, ".key_load"}, 128'(key_load), 128'd0);
    chk({tag, ".rnd_last"}, 128'(rnd_last), 128'd0);
    chk({tag, ".rk_round"}, 128'(rk_round), 128'd0);
    chk({tag, ".state"}, rnd_state, 128'd0);
    chk({tag, ".cipher_key"}, cipher_key, 128'd0);
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge after acceptance.
  task automatic start(input logic [127:0] pt, input logic [127:0] key, input string tag);
    chk({tag, ".idle_rdy"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_block = pt; in_key = key;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, ".key_load"}, 128'(key_load), 128'd1);
    chk({tag, ".cipher_key"}, cipher_key, key);
    chk({tag, ".busy"}, 128'(in_ready), 128'd0);
  endtask

  // smask bit r: hold rk_valid low for 3 cycles while round r is requested.
  task automatic run_txn(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                         input int smask, input int lat, input int bp, input string tag);
    int k, er, sc;
    logic [127:0] exp_s;
    start(pt, key, tag);
    k = 0; er = 0; sc = 0; exp_s = pt;
    while (!out_valid && k < 200) begin
      chk({tag, ".rk_req"}, 128'(rk_req), 128'd1);
      chk({tag, ".rk_round"}, 128'(rk_round), 128'(er));
      chk({tag, ".rnd_last"}, 128'(rnd_last), 128'(er == 10));
      chk({tag, ".state"}, rnd_state, exp_s);
      stall = smask[er % 32] && sc < 3;
      if (stall) sc++;
      else begin
        exp_s = ((er == 0) ? exp_s : tb_round(exp_s, er == 10)) ^ tb_rkey(key, er);
        sc = 0;
        er++;
      end
      @(negedge clk);
      k++;
    end
    stall = 1'b0;
    chk({tag, ".latency"}, 128'(k), 128'(lat));
    chk({tag, ".out_block"}, out_block, ct);
    chk({tag, ".done_req"}, 128'(rk_req), 128'd0);
    chk({tag, ".done_last"}, 128'(rnd_last), 128'd0);
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1; in_block = ~pt; in_key = ~key; spur = (i == 2);
      @(negedge clk);
      chk({tag, ".bp_valid"}, 128'(out_valid), 128'd1);
      chk({tag, ".bp_block"}, out_block, ct);
      chk({tag, ".bp_rdy"}, 128'(in_ready), 128'd0);
      chk({tag, ".bp_kload"}, 128'(key_load), 128'd0);
    end
    spur = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ".drained"}, 128'(out_valid), 128'd0);
    chk({tag, ".rdy_back"}, 128'(in_ready), 128'd1);
    chk({tag, ".state_kept"}, rnd_state, ct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_block = '0; in_key = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk_reset("spur_idle0");

    run_txn(PT_B, KEY_B, CT_B, 0, 11, 0, "fips_b");
    run_txn(PT_C, KEY_C, CT_C, 0, 11, 0, "fips_c1");

    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_idle.state", rnd_state, CT_C);
    chk("spur_idle.out_valid", 128'(out_valid), 128'd0);
    chk("spur_idle.rk_req", 128'(rk_req), 128'd0);
    chk("spur_idle.in_ready", 128'(in_ready), 128'd1);

    run_txn(PT_B, KEY_B, CT_B, (1 << 0) | (1 << 5) | (1 << 10), 20, 0, "stall");
    run_txn(PT_B, KEY_B, CT_B, 0, 11, 8, "bp");

    start(PT_B, KEY_B, "abort");
    w = 0;
    while (rk_round != 4'd4 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("abort.reach_r4", 128'(rk_round), 128'd4);
    rst_n = 1'b0;
    #1;
    chk_reset("rst_mid0");
    @(negedge clk);
    chk_reset("rst_mid1");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort.no_out", 128'(out_valid), 128'd0);
    end
    run_txn(PT_C, KEY_C, CT_C, 0, 11, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
